// File: rtl/multi_chain_scan_controller_if.sv
// Command, scan and functional-data bundle between the instrument layer (master)
// and the multi-chain scan controller (slave).
interface multi_chain_scan_controller_if #(
    parameter int CHAIN_LENGTH = 32,
    parameter int NUM_CHAINS   = 4
);
    logic                    start;
    logic [1:0]              mode;
    logic                    do_capture;
    logic                    do_update;
    logic                    abort;
    logic                    scan_in;
    logic                    scan_out;
    logic [NUM_CHAINS-1:0]   par_scan_in;
    logic [NUM_CHAINS-1:0]   par_scan_out;
    logic                    shift_strobe;
    logic [CHAIN_LENGTH-1:0] functional_data_in;
    logic [CHAIN_LENGTH-1:0] functional_data_out;
    logic                    busy;
    logic                    done;
    logic [15:0]             scan_length;
    logic [31:0]             scan_cycles;

    modport master (
        output start, mode, do_capture, do_update, abort, scan_in, par_scan_in,
               functional_data_in,
        input  scan_out, par_scan_out, shift_strobe, functional_data_out, busy, done,
               scan_length, scan_cycles
    );

    modport slave (
        input  start, mode, do_capture, do_update, abort, scan_in, par_scan_in,
               functional_data_in,
        output scan_out, par_scan_out, shift_strobe, functional_data_out, busy, done,
               scan_length, scan_cycles
    );
endinterface

// File: rtl/multi_chain_scan_controller.sv
// Scan-chain controller: one register run as a serial chain, parallel segments,
// broadcast/XOR-compacted segments or a half-rate chain, sequenced by a command FSM.
module multi_chain_scan_controller #(
    parameter int CHAIN_LENGTH = 32,
    parameter int NUM_CHAINS   = 4
) (
    input  logic clk,
    input  logic reset,
    multi_chain_scan_controller_if.slave bus
);
    localparam int          SEG      = CHAIN_LENGTH / NUM_CHAINS;
    localparam logic [15:0] LEN_FULL = 16'(CHAIN_LENGTH);
    localparam logic [15:0] LEN_SEG  = 16'(SEG);

    if (CHAIN_LENGTH % NUM_CHAINS != 0) begin : g_bad_params
        $error("CHAIN_LENGTH must be a multiple of NUM_CHAINS");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SHIFT,
        ST_UPDATE,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_NORMAL     = 2'b00,
        MODE_PARALLEL   = 2'b01,
        MODE_COMPRESSED = 2'b10,
        MODE_POWER      = 2'b11
    } mode_t;

    state_t                  state;
    state_t                  next_state;
    mode_t                   mode_q;
    logic                    update_q;
    logic                    phase;
    logic [15:0]             strobe_cnt;
    logic [15:0]             scan_length_q;
    logic [31:0]             scan_cycles_q;
    logic [CHAIN_LENGTH-1:0] scan_reg;
    logic [CHAIN_LENGTH-1:0] func_out_q;
    logic [CHAIN_LENGTH-1:0] serial_next;
    logic [CHAIN_LENGTH-1:0] seg_next;
    logic [CHAIN_LENGTH-1:0] shifted;
    logic [NUM_CHAINS-1:0]   seg_lsb;
    logic [NUM_CHAINS-1:0]   seg_msb_in;
    logic                    accept;
    logic                    strobe;
    logic                    busy_i;
    logic                    done_i;

    // Each segment shifts toward its LSB and takes its own (or the broadcast) input at its MSB.
    for (genvar k = 0; k < NUM_CHAINS; k++) begin : g_seg
        assign seg_lsb[k]    = scan_reg[k*SEG];
        assign seg_msb_in[k] = (mode_q == MODE_PARALLEL) ? bus.par_scan_in[k] : bus.scan_in;
        if (SEG > 1) begin : g_wide
            assign seg_next[k*SEG +: SEG] = {seg_msb_in[k], scan_reg[k*SEG+1 +: SEG-1]};
        end else begin : g_narrow
            assign seg_next[k] = seg_msb_in[k];
        end
    end

    assign serial_next = {bus.scan_in, scan_reg[CHAIN_LENGTH-1:1]};
    assign shifted     = (mode_q == MODE_NORMAL || mode_q == MODE_POWER) ? serial_next : seg_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Abort overrides every transition and suppresses the strobe so the chain keeps its partial contents.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        strobe     = 1'b0;
        done_i     = 1'b0;
        busy_i     = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = bus.do_capture ? ST_CAPTURE : ST_SHIFT;
                end
            end
            ST_CAPTURE: next_state = ST_SHIFT;
            ST_SHIFT: begin
                strobe = (mode_q != MODE_POWER) || !phase;
                if (strobe && strobe_cnt == scan_length_q - 16'd1) begin
                    next_state = update_q ? ST_UPDATE : ST_DONE;
                end
            end
            ST_UPDATE: next_state = ST_DONE;
            ST_DONE: begin
                done_i     = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        if (bus.abort && state != ST_IDLE) begin
            next_state = ST_IDLE;
            strobe     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q        <= MODE_NORMAL;
            update_q      <= 1'b0;
            phase         <= 1'b0;
            strobe_cnt    <= '0;
            scan_length_q <= LEN_FULL;
            scan_cycles_q <= '0;
            scan_reg      <= '0;
            func_out_q    <= '0;
        end else begin
            if (accept) begin
                mode_q        <= mode_t'(bus.mode);
                update_q      <= bus.do_update;
                phase         <= 1'b0;
                strobe_cnt    <= '0;
                scan_cycles_q <= '0;
                scan_length_q <= (bus.mode == MODE_PARALLEL || bus.mode == MODE_COMPRESSED)
                                 ? LEN_SEG : LEN_FULL;
            end
            if (state == ST_CAPTURE && !bus.abort) begin
                scan_reg <= bus.functional_data_in;
            end
            if (state == ST_SHIFT) begin
                phase <= ~phase;
                if (scan_cycles_q != 32'hFFFF_FFFF) begin
                    scan_cycles_q <= scan_cycles_q + 32'd1;
                end
            end
            if (strobe) begin
                scan_reg   <= shifted;
                strobe_cnt <= strobe_cnt + 16'd1;
            end
            if (state == ST_UPDATE && !bus.abort) begin
                func_out_q <= scan_reg;
            end
        end
    end

    assign bus.scan_out            = (mode_q == MODE_PARALLEL)   ? 1'b0 :
                                     (mode_q == MODE_COMPRESSED) ? ^seg_lsb : scan_reg[0];
    assign bus.par_scan_out        = (mode_q == MODE_PARALLEL) ? seg_lsb : '0;
    assign bus.shift_strobe        = strobe;
    assign bus.functional_data_out = func_out_q;
    assign bus.busy                = busy_i;
    assign bus.done                = done_i;
    assign bus.scan_length         = scan_length_q;
    assign bus.scan_cycles         = scan_cycles_q;
endmodule

// File: tb/tb_multi_chain_scan_controller.sv
// Table-driven bench for multi_chain_scan_controller plus hand sequences for
// abort, start-while-busy and asynchronous reset mid-command.
module tb_multi_chain_scan_controller;
    localparam int CL = 32;
    localparam int NC = 4;
    localparam logic [1:0] M_NORMAL     = 2'b00;
    localparam logic [1:0] M_PARALLEL   = 2'b01;
    localparam logic [1:0] M_COMPRESSED = 2'b10;
    localparam logic [1:0] M_POWER      = 2'b11;

    typedef struct {
        logic [1:0]  mode;
        logic        cap;
        logic        upd;
        logic [31:0] cap_data;
        logic [31:0] pattern;
        logic        check_stream;
        logic [31:0] exp_stream;
        logic [3:0]  exp_first;
        logic [31:0] exp_func;
        logic [15:0] exp_len;
        logic [31:0] exp_cycles;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    vec_t        vecs[6];
    int          obs_strobes;
    int          obs_done;
    int          unused_bad;
    int          func_bad;
    int          gap_bad;
    logic        timed_out;
    logic [3:0]  obs_first;
    logic [31:0] obs_stream;
    logic        post_busy;
    logic        post_done;

    multi_chain_scan_controller_if #(.CHAIN_LENGTH(CL), .NUM_CHAINS(NC)) bus ();

    multi_chain_scan_controller #(.CHAIN_LENGTH(CL), .NUM_CHAINS(NC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one command and records what the DUT presented along the way.
    task automatic applyStimulus(input vec_t v);
        logic [31:0] prev_func;
        int          last_c;
        @(negedge clk);
        bus.mode               = v.mode;
        bus.do_capture         = v.cap;
        bus.do_update          = v.upd;
        bus.functional_data_in = v.cap_data;
        bus.start              = 1'b1;
        prev_func              = bus.functional_data_out;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.mode      = ~v.mode;
        bus.do_update = ~v.upd;
        obs_strobes = 0;
        obs_done    = 0;
        unused_bad  = 0;
        func_bad    = 0;
        gap_bad     = 0;
        obs_first   = '0;
        obs_stream  = '0;
        timed_out   = 1'b1;
        post_busy   = 1'b1;
        post_done   = 1'b1;
        last_c      = 0;
        for (int c = 0; c < 300; c++) begin
            if (bus.busy && !bus.done && bus.functional_data_out !== prev_func) func_bad++;
            if (bus.shift_strobe) begin
                if (obs_strobes == 0)
                    obs_first = (v.mode == M_PARALLEL) ? bus.par_scan_out : {3'b000, bus.scan_out};
                else if (c - last_c != ((v.mode == M_POWER) ? 2 : 1))
                    gap_bad++;
                if (obs_strobes < 32) obs_stream[obs_strobes] = bus.scan_out;
                if (v.mode == M_PARALLEL ? (bus.scan_out !== 1'b0) : (bus.par_scan_out !== 4'b0000))
                    unused_bad++;
                bus.scan_in     = v.pattern[obs_strobes % 32];
                bus.par_scan_in = v.pattern[3:0];
                last_c          = c;
                obs_strobes++;
            end
            if (bus.done) begin
                obs_done++;
                @(negedge clk);
                post_busy = bus.busy;
                post_done = bus.done;
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        bus.mode      = v.mode;
        bus.do_update = v.upd;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        string p;
        p = $sformatf("vec%0d", idx);
        checkVal({p, " timeout"}, {31'b0, timed_out}, 32'd0);
        checkVal({p, " strobes"}, obs_strobes, {16'b0, v.exp_len});
        checkVal({p, " first_out"}, {28'b0, obs_first}, {28'b0, v.exp_first});
        if (v.check_stream) checkVal({p, " scan_out_stream"}, obs_stream, v.exp_stream);
        checkVal({p, " functional_data_out"}, bus.functional_data_out, v.exp_func);
        checkVal({p, " scan_length"}, {16'b0, bus.scan_length}, {16'b0, v.exp_len});
        checkVal({p, " scan_cycles"}, bus.scan_cycles, v.exp_cycles);
        checkVal({p, " done_pulses"}, obs_done, 32'd1);
        checkVal({p, " idle_after_done"}, {30'b0, post_busy, post_done}, 32'd0);
        checkVal({p, " unused_outputs"}, unused_bad, 32'd0);
        checkVal({p, " func_out_stable"}, func_bad, 32'd0);
        checkVal({p, " strobe_spacing"}, gap_bad, 32'd0);
    endtask

    initial begin
        int          strobes;
        int          dones;
        logic        aborted;
        logic [31:0] func_before;

        total = 0;
        bad   = 0;
        //          mode          cap   upd   cap_data      pattern       chk   stream        first    func          len     cycles
        vecs[0] = '{M_POWER,      1'b0, 1'b1, 32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 4'b0000, 32'hFFFFFFFF, 16'd32, 32'd63};
        vecs[1] = '{M_NORMAL,     1'b1, 1'b1, 32'h12345678, 32'hA5A5A5A5, 1'b1, 32'h12345678, 4'b0000, 32'hA5A5A5A5, 16'd32, 32'd32};
        vecs[2] = '{M_PARALLEL,   1'b1, 1'b1, 32'h00FF00FF, 32'h0000000A, 1'b0, 32'h00000000, 4'b0101, 32'hFF00FF00, 16'd8,  32'd8};
        vecs[3] = '{M_COMPRESSED, 1'b1, 1'b1, 32'h00000001, 32'hFFFFFFFF, 1'b0, 32'h00000000, 4'b0001, 32'hFFFFFFFF, 16'd8,  32'd8};
        vecs[4] = '{M_NORMAL,     1'b0, 1'b0, 32'h00000000, 32'h0F0F0F0F, 1'b1, 32'hFFFFFFFF, 4'b0001, 32'hFFFFFFFF, 16'd32, 32'd32};
        vecs[5] = '{M_COMPRESSED, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, 32'h00000000, 16'd8,  32'd8};

        reset                  = 1'b0;
        bus.start              = 1'b0;
        bus.mode               = M_NORMAL;
        bus.do_capture         = 1'b0;
        bus.do_update          = 1'b0;
        bus.abort              = 1'b0;
        bus.scan_in            = 1'b0;
        bus.par_scan_in        = '0;
        bus.functional_data_in = '0;
        repeat (3) @(negedge clk);
        checkVal("reset busy", {31'b0, bus.busy}, 32'd0);
        checkVal("reset done", {31'b0, bus.done}, 32'd0);
        checkVal("reset shift_strobe", {31'b0, bus.shift_strobe}, 32'd0);
        checkVal("reset scan_cycles", bus.scan_cycles, 32'd0);
        checkVal("reset scan_length", {16'b0, bus.scan_length}, 32'd32);
        checkVal("reset functional_data_out", bus.functional_data_out, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end

        // Abort on the 10th shift cycle, with an ignored start pulse earlier in the shift.
        @(negedge clk);
        func_before            = bus.functional_data_out;
        bus.mode               = M_NORMAL;
        bus.do_capture         = 1'b1;
        bus.do_update          = 1'b1;
        bus.functional_data_in = 32'hDEADBEEF;
        bus.start              = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        strobes   = 0;
        aborted   = 1'b0;
        for (int c = 0; c < 100; c++) begin
            bus.start = 1'b0;
            bus.mode  = M_NORMAL;
            if (bus.shift_strobe) begin
                strobes++;
                if (strobes == 3) begin
                    bus.start = 1'b1;
                    bus.mode  = M_PARALLEL;
                end
                if (strobes == 10) begin
                    bus.abort = 1'b1;
                    @(negedge clk);
                    bus.abort = 1'b0;
                    aborted   = 1'b1;
                    break;
                end
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.mode  = M_NORMAL;
        checkVal("abort reached", {31'b0, aborted}, 32'd1);
        checkVal("abort busy", {31'b0, bus.busy}, 32'd0);
        checkVal("abort shift_strobe", {31'b0, bus.shift_strobe}, 32'd0);
        checkVal("abort done", {31'b0, bus.done}, 32'd0);
        checkVal("busy start ignored scan_length", {16'b0, bus.scan_length}, 32'd32);
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        checkVal("abort no done later", dones, 32'd0);
        checkVal("abort functional_data_out", bus.functional_data_out, func_before);

        // Asynchronous reset in the middle of a shift, then a fresh command.
        applyStimulus(vecs[3]);
        checkOutput(3, vecs[3]);
        @(negedge clk);
        bus.mode       = M_NORMAL;
        bus.do_capture = 1'b0;
        bus.do_update  = 1'b1;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        checkVal("pre-reset busy", {31'b0, bus.busy}, 32'd1);
        checkVal("pre-reset shift_strobe", {31'b0, bus.shift_strobe}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkVal("async reset busy", {31'b0, bus.busy}, 32'd0);
        checkVal("async reset shift_strobe", {31'b0, bus.shift_strobe}, 32'd0);
        checkVal("async reset scan_cycles", bus.scan_cycles, 32'd0);
        checkVal("async reset functional_data_out", bus.functional_data_out, 32'd0);
        checkVal("async reset done", {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(vecs[2]);
        checkOutput(2, vecs[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
